command_credit_arbiter: RTL and testbench
=========================================

COMMAND_CREDIT_ARBITER -- requirements
Module: command_credit_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, 4, number of command sources (index 0 = restart, 1 = WED, 2 = read, 3 = write).
REQ-002 SHALL have parameter CREDIT_WIDTH, 8, width of the credit and outstanding counters.
REQ-003 SHALL have parameter TAG_WIDTH, 8, width of the issued command tag.
REQ-004 SHALL have port clock  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enabled_in  in  1  job running.
REQ-007 SHALL have port command_room_in  in  CREDIT_WIDTH  initial PSL credit count.
REQ-008 SHALL have port req_valid_in  in  NUM_REQUESTERS  per-source command pending.
REQ-009 SHALL have port grant_out  out  NUM_REQUESTERS  one-hot grant, combinational.
REQ-010 SHALL have port cmd_valid_out  out  1  registered command issue strobe.
REQ-011 SHALL have port cmd_tag_out  out  TAG_WIDTH  tag of the issued command.
REQ-012 SHALL have port cmd_source_out  out  clog2(NUM_REQUESTERS)  index of the issuing source.
REQ-013 SHALL have port response_valid_in  in  1  PSL response strobe.
REQ-014 SHALL have port response_credits_in  in  9  signed credits returned with the response.
REQ-015 SHALL have port credits_out  out  CREDIT_WIDTH  current available credits.
REQ-016 SHALL have port outstanding_out  out  CREDIT_WIDTH  commands issued but not yet responded to.
REQ-017 SHALL have port credit_error_out  out  1  sticky credit overflow/underflow flag.
REQ-018 SHALL have port drained_out  out  1  high in DISABLED state.

Function
REQ-019 SHALL implement FSM states DISABLED, INIT, RUN and DRAIN.
REQ-020 SHALL transition DISABLED->INIT when enabled_in=1.
REQ-021 SHALL, in INIT, load credits from command_room_in, clear outstanding, and go to RUN the next cycle.
REQ-022 SHALL transition RUN->DRAIN when enabled_in=0.
REQ-023 SHALL transition DRAIN->DISABLED when outstanding==0; DRAIN SHALL return to RUN if enabled_in rises again first.
REQ-024 SHALL issue grants only in RUN, and only when credits>0 and at least one req_valid_in bit is set.
REQ-025 SHALL give req_valid_in[0] strict priority; indices 1..3 SHALL share round-robin, with the pointer advancing past the last granted non-restart index.
REQ-026 SHALL drive grant_out in the same cycle as req_valid_in; cmd_valid_out, cmd_tag_out and cmd_source_out SHALL register one cycle later (latency 1).
REQ-027 SHALL increment the tag after each issue and wrap from 2^TAG_WIDTH-1 to 0.
REQ-028 SHALL update credits per cycle as credits - issue + (response_valid_in ? response_credits_in : 0); simultaneous issue and response SHALL combine in one update.
REQ-029 SHALL update outstanding as +issue - response_valid_in; simultaneous events SHALL leave it unchanged.
REQ-030 SHALL, if a credit result would exceed the INIT-loaded room or fall below 0, clamp it to the bound and set credit_error_out, which SHALL stay set until reset.
REQ-031 SHALL ignore a response arriving with outstanding==0 and set credit_error_out.

Reset
REQ-032 SHALL, on reset assertion at any time including mid-DRAIN, force state DISABLED, grant_out=0, cmd_valid_out=0, tag=0, credits=0, outstanding=0, credit_error_out=0, drained_out=1 and RR pointer=1, asynchronously.
REQ-033 SHALL release from reset synchronously on the first rising edge after deassertion.

Structure
REQ-034 SHALL place the state enum and the requester index constants in AFU_PKG.
REQ-035 SHALL implement round-robin selection in one sub-module, round_robin_priority_select.

Verification
REQ-036 SHALL cover: room=4, all four sources requesting continuously -> grant order 0,0,0,0 (restart wins), credits reach 0, no further grants.
REQ-037 SHALL cover: room=8, sources 1..3 requesting -> grants 1,2,3,1,2,3 and tags 0..5 on cmd_tag_out one cycle after each grant.
REQ-038 SHALL cover: 256 issues with room=1 and one response (+1 credit) after each -> tag wraps 255->0 and credit_error_out stays 0.
REQ-039 SHALL cover: issue and response(+1) in the same cycle at credits=3 -> credits stays 3 and outstanding is unchanged.
REQ-040 SHALL cover: enabled_in drops with 2 outstanding -> no grants, DRAIN held until two responses arrive, then drained_out=1.
REQ-041 SHALL cover: response credits +5 with room=4 and credits=2 -> credits clamps to 4 and credit_error_out=1; reset then clears it.

Source files
------------

// File: rtl/command_credit_arbiter_pkg.sv
// Shared types and constants for the AFU command credit arbiter.
// Holds the arbiter FSM encoding and the fixed requester slot assignment.
package afu_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_INIT     = 2'd1,
        ST_RUN      = 2'd2,
        ST_DRAIN    = 2'd3
    } arb_state_t;

    localparam int REQ_RESTART = 0;
    localparam int REQ_WED     = 1;
    localparam int REQ_READ    = 2;
    localparam int REQ_WRITE   = 3;

    localparam int RESP_CREDIT_WIDTH = 9;

endpackage

// File: rtl/command_credit_arbiter_if.sv
// Bundle of command request, issue and PSL response signals around the arbiter.
// The master side is the command sources plus the PSL; the slave side is the arbiter.
interface command_credit_arbiter_if
    import afu_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int CREDIT_WIDTH   = 8,
    parameter int TAG_WIDTH      = 8
);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    // Handshake: req_valid_in[i] holds a pending command; grant_out[i] in the same
    // cycle means it was accepted. cmd_valid_out is a one-cycle strobe with no ready.
    logic                                enabled_in;
    logic [CREDIT_WIDTH-1:0]             command_room_in;
    logic [NUM_REQUESTERS-1:0]           req_valid_in;
    logic [NUM_REQUESTERS-1:0]           grant_out;
    logic                                cmd_valid_out;
    logic [TAG_WIDTH-1:0]                cmd_tag_out;
    logic [IDX_W-1:0]                    cmd_source_out;
    logic                                response_valid_in;
    logic signed [RESP_CREDIT_WIDTH-1:0] response_credits_in;
    logic [CREDIT_WIDTH-1:0]             credits_out;
    logic [CREDIT_WIDTH-1:0]             outstanding_out;
    logic                                credit_error_out;
    logic                                drained_out;
    arb_state_t                          state_dbg;

    modport master (
        output enabled_in, command_room_in, req_valid_in,
               response_valid_in, response_credits_in,
        input  grant_out, cmd_valid_out, cmd_tag_out, cmd_source_out,
               credits_out, outstanding_out, credit_error_out, drained_out, state_dbg
    );

    modport slave (
        input  enabled_in, command_room_in, req_valid_in,
               response_valid_in, response_credits_in,
        output grant_out, cmd_valid_out, cmd_tag_out, cmd_source_out,
               credits_out, outstanding_out, credit_error_out, drained_out, state_dbg
    );

endinterface

// File: rtl/command_credit_arbiter_round_robin_priority_select.sv
// Requester selection: the restart slot always wins, the remaining slots rotate
// starting from rr_ptr (which must lie in 1..NUM_REQUESTERS-1).
module round_robin_priority_select
    import afu_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int IDX_W          = 2
) (
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]          rr_ptr,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      grant_any
);
    localparam int NUM_RR = NUM_REQUESTERS - 1;

    function automatic logic [IDX_W-1:0] cand_idx(input logic [IDX_W-1:0] p, input int k);
        return IDX_W'(((int'(p) - 1 + k) % NUM_RR) + 1);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (req[REQ_RESTART]) begin
            grant[REQ_RESTART] = 1'b1;
            grant_idx          = IDX_W'(REQ_RESTART);
            grant_any          = 1'b1;
        end else begin
            for (int k = 0; k < NUM_RR; k++) begin
                if (!grant_any && req[cand_idx(rr_ptr, k)]) begin
                    grant[cand_idx(rr_ptr, k)] = 1'b1;
                    grant_idx                  = cand_idx(rr_ptr, k);
                    grant_any                  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/command_credit_arbiter.sv
// Credit-gated command arbiter: grants one source per cycle while credits last,
// tags issued commands, and tracks PSL credits and outstanding commands.
module command_credit_arbiter
    import afu_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int CREDIT_WIDTH   = 8,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    command_credit_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    // Wide enough for credits plus a signed 9-bit response without wrapping.
    localparam int SW = ((CREDIT_WIDTH > RESP_CREDIT_WIDTH) ? CREDIT_WIDTH : RESP_CREDIT_WIDTH) + 2;

    arb_state_t              state_q, state_next;
    logic [CREDIT_WIDTH-1:0] credits_q, room_q, outstanding_q;
    logic [CREDIT_WIDTH-1:0] credits_next, outstanding_next;
    logic [TAG_WIDTH-1:0]    tag_q, cmd_tag_q;
    logic [IDX_W-1:0]        rr_ptr_q, cmd_source_q;
    logic                    cmd_valid_q, credit_error_q;

    logic [NUM_REQUESTERS-1:0] sel_grant;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_any;
    logic                      issue_ok, issue;
    logic                      resp_accept, resp_orphan, credit_clip;
    logic signed [SW-1:0]      credit_sum, room_ext, resp_ext;

    round_robin_priority_select #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .IDX_W          (IDX_W)
    ) u_select (
        .req       (bus.req_valid_in),
        .rr_ptr    (rr_ptr_q),
        .grant     (sel_grant),
        .grant_idx (sel_idx),
        .grant_any (sel_any)
    );

    assign issue_ok      = (state_q == ST_RUN) && (credits_q != '0);
    assign issue         = issue_ok && sel_any;
    assign bus.grant_out = issue_ok ? sel_grant : '0;

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_DISABLED: if (bus.enabled_in) state_next = ST_INIT;
            ST_INIT:     state_next = ST_RUN;
            ST_RUN:      if (!bus.enabled_in) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.enabled_in)           state_next = ST_RUN;
                else if (outstanding_q == '0) state_next = ST_DISABLED;
            end
            default:     state_next = ST_DISABLED;
        endcase
    end

    // A response with nothing outstanding carries no meaningful credit; drop it.
    always_comb begin
        resp_accept = bus.response_valid_in && (outstanding_q != '0);
        resp_orphan = bus.response_valid_in && (outstanding_q == '0);
        resp_ext    = resp_accept
                    ? {{(SW-RESP_CREDIT_WIDTH){bus.response_credits_in[RESP_CREDIT_WIDTH-1]}},
                       bus.response_credits_in}
                    : '0;
        room_ext    = {{(SW-CREDIT_WIDTH){1'b0}}, room_q};
        credit_sum  = {{(SW-CREDIT_WIDTH){1'b0}}, credits_q} - {{(SW-1){1'b0}}, issue} + resp_ext;
        credit_clip = 1'b0;
        if (credit_sum > room_ext) begin
            credits_next = room_q;
            credit_clip  = 1'b1;
        end else if (credit_sum < 0) begin
            credits_next = '0;
            credit_clip  = 1'b1;
        end else begin
            credits_next = credit_sum[CREDIT_WIDTH-1:0];
        end
        outstanding_next = outstanding_q + CREDIT_WIDTH'(issue) - CREDIT_WIDTH'(resp_accept);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_DISABLED;
            credits_q      <= '0;
            room_q         <= '0;
            outstanding_q  <= '0;
            tag_q          <= '0;
            cmd_tag_q      <= '0;
            cmd_source_q   <= '0;
            cmd_valid_q    <= 1'b0;
            credit_error_q <= 1'b0;
            rr_ptr_q       <= IDX_W'(1);
        end else begin
            state_q     <= state_next;
            cmd_valid_q <= issue;
            if (issue) begin
                cmd_tag_q    <= tag_q;
                cmd_source_q <= sel_idx;
                tag_q        <= tag_q + 1'b1;
                if (sel_idx != IDX_W'(REQ_RESTART))
                    rr_ptr_q <= (sel_idx == IDX_W'(NUM_REQUESTERS - 1)) ? IDX_W'(1) : sel_idx + 1'b1;
            end
            if (state_q == ST_INIT) begin
                credits_q     <= bus.command_room_in;
                room_q        <= bus.command_room_in;
                outstanding_q <= '0;
            end else begin
                credits_q     <= credits_next;
                outstanding_q <= outstanding_next;
                if (credit_clip || resp_orphan) credit_error_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_valid_out    = cmd_valid_q;
    assign bus.cmd_tag_out      = cmd_tag_q;
    assign bus.cmd_source_out   = cmd_source_q;
    assign bus.credits_out      = credits_q;
    assign bus.outstanding_out  = outstanding_q;
    assign bus.credit_error_out = credit_error_q;
    assign bus.drained_out      = (state_q == ST_DISABLED);
    assign bus.state_dbg        = state_q;

endmodule

// File: tb/tb_command_credit_arbiter.sv
// Bench for command_credit_arbiter: directed scenarios plus random traffic, with
// a behavioural model predicting grants and a scoreboard for issued commands.
module tb_command_credit_arbiter;
    import afu_pkg::*;

    localparam int NR = 4;
    localparam int CW = 8;
    localparam int TW = 8;
    localparam int M_OFF = 0, M_LOAD = 1, M_GO = 2, M_WAIT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    command_credit_arbiter_if #(.NUM_REQUESTERS(NR), .CREDIT_WIDTH(CW), .TAG_WIDTH(TW)) bus ();

    command_credit_arbiter #(.NUM_REQUESTERS(NR), .CREDIT_WIDTH(CW), .TAG_WIDTH(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [TW+1:0] exp_q[$];

    // Reference model: phase, credits, room, outstanding, next tag, rotation start.
    int m_st, m_credits, m_room, m_out, m_tag, m_ptr;
    bit m_err;
    int room_v;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_OFF; m_credits = 0; m_room = 0; m_out = 0;
        m_tag = 0; m_ptr = 1; m_err = 1'b0;
        exp_q.delete();
    endtask

    // Inputs are left as they were at assertion so the async clearing is observable.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_grant", int'(bus.grant_out), 0);
        check("reset_cmd_valid", int'(bus.cmd_valid_out), 0);
        check("reset_credits", int'(bus.credits_out), 0);
        check("reset_outstanding", int'(bus.outstanding_out), 0);
        check("reset_error", int'(bus.credit_error_out), 0);
        check("reset_drained", int'(bus.drained_out), 1);
        check("reset_state", int'(bus.state_dbg), int'(ST_DISABLED));
        bus.enabled_in = 1'b0; bus.req_valid_in = '0;
        bus.response_valid_in = 1'b0; bus.response_credits_in = '0;
        bus.command_room_in = CW'(room_v);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input bit en, input logic [NR-1:0] req, input bit rv, input int rc);
        int g;
        int sum;
        int old_out;
        int c;
        bit acc;
        @(negedge clock);
        bus.enabled_in = en; bus.req_valid_in = req;
        bus.response_valid_in = rv; bus.response_credits_in = 9'(rc);
        bus.command_room_in = CW'(room_v);
        #1;
        g = -1;
        if (m_st == M_GO && m_credits > 0 && req != '0) begin
            if (req[0]) g = 0;
            else for (int k = 0; k < NR - 1; k++) begin
                c = ((m_ptr - 1 + k) % (NR - 1)) + 1;
                if (g < 0 && req[c]) g = c;
            end
        end
        check("grant", int'(bus.grant_out), (g >= 0) ? (1 << g) : 0);
        check("credits", int'(bus.credits_out), m_credits);
        check("outstanding", int'(bus.outstanding_out), m_out);
        check("credit_error", int'(bus.credit_error_out), int'(m_err));
        check("drained", int'(bus.drained_out), int'(m_st == M_OFF));
        if (g >= 0) begin
            exp_q.push_back({TW'(m_tag), 2'(g)});
            m_tag = (m_tag + 1) % (1 << TW);
            if (g != 0) m_ptr = (g % (NR - 1)) + 1;
        end
        old_out = m_out;
        if (m_st == M_LOAD) begin
            m_credits = room_v; m_room = room_v; m_out = 0;
        end else begin
            acc = rv && (m_out > 0);
            if (rv && m_out == 0) m_err = 1'b1;
            sum = m_credits - int'(g >= 0) + (acc ? rc : 0);
            if (sum > m_room) begin sum = m_room; m_err = 1'b1; end
            else if (sum < 0) begin sum = 0; m_err = 1'b1; end
            m_credits = sum;
            m_out = m_out + int'(g >= 0) - int'(acc);
        end
        case (m_st)
            M_OFF:   if (en) m_st = M_LOAD;
            M_LOAD:  m_st = M_GO;
            M_GO:    if (!en) m_st = M_WAIT;
            default: if (en) m_st = M_GO; else if (old_out == 0) m_st = M_OFF;
        endcase
    endtask

    initial begin : monitor
        logic [TW+1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (bus.cmd_valid_out) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL cmd_unexpected: got tag %0d source %0d, expected no command",
                             bus.cmd_tag_out, bus.cmd_source_out);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_tag", int'(bus.cmd_tag_out), int'(e[TW+1:2]));
                    check("cmd_source", int'(bus.cmd_source_out), int'(e[1:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bus.enabled_in = 1'b0; bus.req_valid_in = '0; bus.command_room_in = '0;
        bus.response_valid_in = 1'b0; bus.response_credits_in = '0;
        room_v = 0;
        model_reset();

        // Restart slot wins every grant until credits run out.
        room_v = 4; do_reset();
        repeat (10) step(1'b1, 4'b1111, 1'b0, 0);
        check("s1_credits_exhausted", int'(bus.credits_out), 0);

        // Rotation over slots 1..3; reset then hits while a grant is being driven.
        room_v = 8; do_reset();
        repeat (9) step(1'b1, 4'b1110, 1'b0, 0);

        // Tag wrap with one credit recycled by each response.
        room_v = 1; do_reset();
        repeat (2) step(1'b1, 4'b0000, 1'b0, 0);
        repeat (256) begin
            step(1'b1, 4'b0100, 1'b0, 0);
            step(1'b1, 4'b0000, 1'b1, 1);
        end
        step(1'b1, 4'b0010, 1'b0, 0);
        step(1'b1, 4'b0000, 1'b0, 0);
        check("s3_error_clear", int'(bus.credit_error_out), 0);

        // Issue and response in the same cycle at credits=3.
        room_v = 4; do_reset();
        repeat (2) step(1'b1, 4'b0000, 1'b0, 0);
        step(1'b1, 4'b0001, 1'b0, 0);
        step(1'b1, 4'b0001, 1'b1, 1);
        step(1'b1, 4'b0000, 1'b0, 0);
        check("s4_credits_held", int'(bus.credits_out), 3);
        check("s4_outstanding_held", int'(bus.outstanding_out), 1);

        // Drain with two outstanding commands.
        room_v = 8; do_reset();
        repeat (2) step(1'b1, 4'b0000, 1'b0, 0);
        repeat (2) step(1'b1, 4'b0010, 1'b0, 0);
        step(1'b0, 4'b0000, 1'b0, 0);
        repeat (4) step(1'b0, 4'b1111, 1'b0, 0);
        check("s5_still_draining", int'(bus.drained_out), 0);
        repeat (2) step(1'b0, 4'b1111, 1'b1, 1);
        repeat (2) step(1'b0, 4'b1111, 1'b0, 0);
        check("s5_drained", int'(bus.drained_out), 1);

        // Reset landing mid-drain.
        room_v = 8; do_reset();
        repeat (2) step(1'b1, 4'b0000, 1'b0, 0);
        step(1'b1, 4'b1000, 1'b0, 0);
        repeat (3) step(1'b0, 4'b1111, 1'b0, 0);
        do_reset();

        // Credit overflow clamps to room and sets the sticky error.
        room_v = 4; do_reset();
        repeat (2) step(1'b1, 4'b0000, 1'b0, 0);
        repeat (2) step(1'b1, 4'b0001, 1'b0, 0);
        step(1'b1, 4'b0000, 1'b1, 5);
        repeat (3) step(1'b1, 4'b0000, 1'b0, 0);
        check("s6_clamped", int'(bus.credits_out), 4);
        check("s6_error_set", int'(bus.credit_error_out), 1);
        do_reset();

        // Random traffic, including enable dips, negative credits and orphan responses.
        for (int ep = 0; ep < 4; ep++) begin
            room_v = int'($urandom_range(1, 12));
            do_reset();
            repeat (150) begin
                step($urandom_range(0, 15) != 0, NR'($urandom_range(0, 15)),
                     $urandom_range(0, 2) == 0, int'($urandom_range(0, 5)) - 2);
            end
        end

        repeat (3) step(1'b0, 4'b0000, 1'b0, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
